// File: rtl/arb_pkg.sv
// Shared definitions for the N-channel arbitrating multiplexer:
// mode encodings and a one-hot to index encoder.
package arb_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_RR    = 2'b01,
        MODE_WRR   = 2'b10,
        MODE_RSVD  = 2'b11
    } arb_mode_e;

    // Encode a one-hot vector (up to 16 channels) into its bit index.
    // For a valid one-hot input the OR of all set positions is the index.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating find-first picker: the request vector is rotated
// so that 'start' lands at bit 0, the lowest set bit is found, and the
// result is mapped back to an absolute channel index.
module rr_pick #(
    parameter int NCH = 4,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  start,
    output logic           found,
    output logic [IW-1:0]  idx,
    output logic [NCH-1:0] onehot
);

    logic [2*NCH-1:0] dbl_s;
    logic [NCH-1:0]   rot_s;
    logic [IW-1:0]    ff_s;
    logic             hit_s;
    logic [IW:0]      sum_s;
    logic [IW-1:0]    abs_s;

    // Rotate requests so that 'start' sits at bit 0, then find the first set bit.
    always_comb begin
        dbl_s = {req, req} >> start;
        rot_s = dbl_s[NCH-1:0];
        ff_s  = {IW{1'b0}};
        hit_s = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                ff_s  = IW'(i);
                hit_s = 1'b1;
            end else begin
                ff_s  = ff_s;
                hit_s = hit_s;
            end
        end
    end

    // Map the rotated position back to an absolute index modulo NCH.
    always_comb begin
        sum_s = {1'b0, start} + {1'b0, ff_s};
        if (sum_s >= (IW+1)'(NCH)) begin
            abs_s = IW'(sum_s - (IW+1)'(NCH));
        end else begin
            abs_s = IW'(sum_s);
        end
        found = hit_s;
        if (hit_s) begin
            idx    = abs_s;
            onehot = {{(NCH-1){1'b0}}, 1'b1} << abs_s;
        end else begin
            idx    = {IW{1'b0}};
            onehot = {NCH{1'b0}};
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbitrating data multiplexer with fixed-priority, round-robin
// and weighted round-robin modes, feeding a single registered valid/ready
// output slot. Winner data, one-hot grant and encoded index are registered.
module arb_mux_n
    import arb_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int WW  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*DW-1:0]      data_in,
    input  logic [NCH*WW-1:0]      weight,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          data_out,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] grant_id
);

    localparam int IW = $clog2(NCH);

    // Registered state
    logic            out_valid_r;
    logic [DW-1:0]   data_out_r;
    logic [NCH-1:0]  grant_r;
    logic [IW-1:0]   grant_id_r;
    logic [IW-1:0]   ptr_r;
    logic [WW-1:0]   credit_r;
    arb_mode_e       last_mode_r;

    // Combinational decode
    arb_mode_e       mode_eff_s;
    logic            mode_chg_s;
    logic            slot_free_s;
    logic            arb_s;
    logic [IW-1:0]   start_s;
    logic            found_s;
    logic [IW-1:0]   win_idx_s;
    logic [NCH-1:0]  win_oh_s;
    logic [15:0]     win_oh16_s;
    logic [3:0]      win_enc_s;
    logic [IW-1:0]   nxt_idx_s;
    logic [DW-1:0]   win_data_s;
    logic [WW-1:0]   win_w_s;
    logic [WW-1:0]   quota_m1_s;
    logic [WW-1:0]   credit_eff_s;
    logic [IW-1:0]   ptr_nxt_s;
    logic [WW-1:0]   credit_nxt_s;

    // Map the mode input onto the three supported behaviours; 11 acts as fixed.
    always_comb begin
        case (mode)
            2'b01:   mode_eff_s = MODE_RR;
            2'b10:   mode_eff_s = MODE_WRR;
            default: mode_eff_s = MODE_FIXED;
        endcase
    end

    // Slot qualification and search start point.
    always_comb begin
        slot_free_s = !out_valid_r || out_ready;
        mode_chg_s  = (mode_eff_s != last_mode_r);
        if (mode_eff_s == MODE_FIXED) begin
            start_s = {IW{1'b0}};
        end else begin
            start_s = ptr_r;
        end
    end

    rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req    (req),
        .start  (start_s),
        .found  (found_s),
        .idx    (win_idx_s),
        .onehot (win_oh_s)
    );

    // Winner data, weight and helper values derived from the picker result.
    always_comb begin
        arb_s      = slot_free_s && found_s;
        win_oh16_s = 16'(win_oh_s);
        win_enc_s  = onehot_to_idx(win_oh16_s);
        win_data_s = data_in[win_idx_s*DW +: DW];
        win_w_s    = weight[win_idx_s*WW +: WW];
        if (win_w_s == {WW{1'b0}}) begin
            quota_m1_s = {WW{1'b0}};
        end else begin
            quota_m1_s = win_w_s - WW'(1);
        end
        if (win_idx_s == IW'(NCH - 1)) begin
            nxt_idx_s = {IW{1'b0}};
        end else begin
            nxt_idx_s = win_idx_s + IW'(1);
        end
        if (mode_chg_s) begin
            credit_eff_s = {WW{1'b0}};
        end else begin
            credit_eff_s = credit_r;
        end
    end

    // Pointer and credit update; only an arbitration moves them.
    always_comb begin
        ptr_nxt_s    = ptr_r;
        credit_nxt_s = credit_r;
        if (arb_s) begin
            credit_nxt_s = credit_eff_s;
            case (mode_eff_s)
                MODE_RR: begin
                    ptr_nxt_s = nxt_idx_s;
                end
                MODE_WRR: begin
                    if (win_idx_s == ptr_r) begin
                        // Owner keeps the slot until its quota is used up.
                        if (credit_eff_s >= quota_m1_s) begin
                            ptr_nxt_s    = nxt_idx_s;
                            credit_nxt_s = {WW{1'b0}};
                        end else begin
                            credit_nxt_s = credit_eff_s + WW'(1);
                        end
                    end else begin
                        // Owner dropped its request; the winner becomes owner.
                        if (win_w_s <= WW'(1)) begin
                            ptr_nxt_s    = nxt_idx_s;
                            credit_nxt_s = {WW{1'b0}};
                        end else begin
                            ptr_nxt_s    = win_idx_s;
                            credit_nxt_s = WW'(1);
                        end
                    end
                end
                default: begin
                    ptr_nxt_s = ptr_r;
                end
            endcase
        end else begin
            ptr_nxt_s    = ptr_r;
            credit_nxt_s = credit_r;
        end
    end

    // Arbitration state registers: pointer, credit and last arbitrated mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= {IW{1'b0}};
            credit_r    <= {WW{1'b0}};
            last_mode_r <= MODE_FIXED;
        end else if (arb_s) begin
            ptr_r       <= ptr_nxt_s;
            credit_r    <= credit_nxt_s;
            last_mode_r <= mode_eff_s;
        end else begin
            ptr_r       <= ptr_r;
            credit_r    <= credit_r;
            last_mode_r <= last_mode_r;
        end
    end

    // Output slot: load on arbitration, empty when free and idle, hold on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {DW{1'b0}};
            grant_r     <= {NCH{1'b0}};
            grant_id_r  <= {IW{1'b0}};
        end else if (arb_s) begin
            out_valid_r <= 1'b1;
            data_out_r  <= win_data_s;
            grant_r     <= win_oh_s;
            grant_id_r  <= IW'(win_enc_s);
        end else if (slot_free_s) begin
            out_valid_r <= 1'b0;
            grant_r     <= {NCH{1'b0}};
        end else begin
            grant_r     <= {NCH{1'b0}};
        end
    end

    assign out_valid = out_valid_r;
    assign data_out  = data_out_r;
    assign grant     = grant_r;
    assign grant_id  = grant_id_r;

endmodule
